// File: rtl/sifive_insight_tl_echo_tracker.sv
// Per-source TileLink echo tracker: captures A-channel echo at A fire, replays it on matching D beats.
// Optional storage parity check enabled by defining SIFIVE_INSIGHT_ECHO_PARITY_EN.
module sifive_insight_tl_echo_tracker #(
   parameter int SOURCE_BITS = 4,
   parameter int ECHO_BITS   = 8,
   parameter int SIZE_BITS   = 3,
   parameter int LG_BEAT     = 3
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   a_valid,
   input  logic                   a_ready,
   input  logic [SOURCE_BITS-1:0] a_source,
   input  logic [ECHO_BITS-1:0]   a_echo,
   input  logic                   d_valid,
   input  logic                   d_ready,
   input  logic [SOURCE_BITS-1:0] d_source,
   input  logic [2:0]             d_opcode,
   input  logic [SIZE_BITS-1:0]   d_size,
   output logic [ECHO_BITS-1:0]   d_echo,
   output logic                   d_echo_valid,
   output logic [SOURCE_BITS:0]   outstanding,
   output logic                   idle,
   input  logic                   err_clear,
`ifdef SIFIVE_INSIGHT_ECHO_PARITY_EN
   output logic                   err_echo_parity,
`endif
   output logic                   err_dup_source,
   output logic                   err_orphan_d
);

   localparam int DEPTH        = 2**SOURCE_BITS;
   localparam int OUT_W        = SOURCE_BITS + 1;
   localparam int MAX_LG_BEATS = ((2**SIZE_BITS) - 1 > LG_BEAT) ? ((2**SIZE_BITS) - 1 - LG_BEAT) : 0;
   localparam int CNT_W        = MAX_LG_BEATS + 1;

   logic [DEPTH-1:0]       valid_r;
   logic [DEPTH-1:0]       valid_nxt_s;
   logic [ECHO_BITS-1:0]   echo_r [DEPTH];
   logic [CNT_W-1:0]       beat_cnt_r;
   logic [CNT_W-1:0]       burst_beats_m1_r;
   logic [CNT_W-1:0]       beats_m1_s;
   logic [CNT_W-1:0]       eff_beats_m1_s;
   logic                   burst_lock_r;
   logic [SOURCE_BITS-1:0] burst_src_r;
   logic [SOURCE_BITS-1:0] eff_src_s;
   logic                   a_fire_s;
   logic                   d_fire_s;
   logic                   data_op_s;
   logic                   last_beat_s;
   logic                   hit_s;
   logic                   free_s;
   logic                   same_src_s;
   logic                   dup_s;
   logic                   orphan_s;
   logic                   inc_s;
   logic                   dec_s;

   assign a_fire_s  = a_valid & a_ready;
   assign d_fire_s  = d_valid & d_ready;
   assign data_op_s = (d_opcode == 3'd1) || (d_opcode == 3'd5);

   // Beats minus one for the current D message; only data opcodes larger than a beat are multi-beat
   always_comb begin
      beats_m1_s = {CNT_W{1'b0}};
      if (data_op_s && (d_size > SIZE_BITS'(LG_BEAT))) begin
         beats_m1_s = (CNT_W'(1) << (d_size - SIZE_BITS'(LG_BEAT))) - CNT_W'(1);
      end else begin
         beats_m1_s = {CNT_W{1'b0}};
      end
   end

   // Mid-burst, the source and length latched at the first beat govern the free
   assign eff_src_s      = burst_lock_r ? burst_src_r : d_source;
   assign eff_beats_m1_s = burst_lock_r ? burst_beats_m1_r : beats_m1_s;
   assign last_beat_s    = (beat_cnt_r == eff_beats_m1_s);
   assign hit_s          = valid_r[eff_src_s];
   assign free_s         = d_fire_s & last_beat_s & hit_s;
   assign same_src_s     = a_fire_s & free_s & (a_source == eff_src_s);
   assign dup_s          = a_fire_s & valid_r[a_source] & ~same_src_s;
   assign orphan_s       = d_fire_s & ~hit_s;
   assign inc_s          = a_fire_s & ~valid_r[a_source];
   assign dec_s          = free_s & ~same_src_s;

   // Next valid bits: allocation overrides a same-cycle free of the same source
   always_comb begin
      valid_nxt_s = valid_r;
      for (int i = 0; i < DEPTH; i++) begin
         valid_nxt_s[i] = (a_fire_s && (a_source == SOURCE_BITS'(i))) ? 1'b1 :
                          (free_s && (eff_src_s == SOURCE_BITS'(i))) ? 1'b0 : valid_r[i];
      end
   end

   assign d_echo       = valid_r[d_source] ? echo_r[d_source] : {ECHO_BITS{1'b0}};
   assign d_echo_valid = d_valid & valid_r[d_source];
   assign idle         = (outstanding == {OUT_W{1'b0}}) & ~burst_lock_r;

   // Echo payload storage; contents are qualified by valid_r so no reset is needed
   always_ff @(posedge clock) begin
      if (a_fire_s) begin
         echo_r[a_source] <= a_echo;
      end
   end

   // Valid table, outstanding count and sticky protocol error flags
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         valid_r        <= {DEPTH{1'b0}};
         outstanding    <= {OUT_W{1'b0}};
         err_dup_source <= 1'b0;
         err_orphan_d   <= 1'b0;
      end else begin
         valid_r        <= valid_nxt_s;
         outstanding    <= outstanding + OUT_W'(inc_s) - OUT_W'(dec_s);
         err_dup_source <= dup_s ? 1'b1 : (err_clear ? 1'b0 : err_dup_source);
         err_orphan_d   <= orphan_s ? 1'b1 : (err_clear ? 1'b0 : err_orphan_d);
      end
   end

   // Beat counter and burst lock; beats are counted even for orphan responses
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         beat_cnt_r       <= {CNT_W{1'b0}};
         burst_lock_r     <= 1'b0;
         burst_src_r      <= {SOURCE_BITS{1'b0}};
         burst_beats_m1_r <= {CNT_W{1'b0}};
      end else if (d_fire_s) begin
         if (!burst_lock_r) begin
            burst_src_r      <= d_source;
            burst_beats_m1_r <= beats_m1_s;
         end
         if (last_beat_s) begin
            beat_cnt_r   <= {CNT_W{1'b0}};
            burst_lock_r <= 1'b0;
         end else begin
            beat_cnt_r   <= beat_cnt_r + CNT_W'(1);
            burst_lock_r <= 1'b1;
         end
      end
   end

`ifdef SIFIVE_INSIGHT_ECHO_PARITY_EN
   function automatic logic even_parity(input logic [ECHO_BITS-1:0] v);
      return ^v;
   endfunction

   logic [DEPTH-1:0] par_r;
   logic             par_err_s;

   assign par_err_s = d_fire_s & hit_s & (par_r[eff_src_s] != even_parity(echo_r[eff_src_s]));

   // Parity captured alongside the echo payload
   always_ff @(posedge clock) begin
      if (a_fire_s) begin
         par_r[a_source] <= even_parity(a_echo);
      end
   end

   // Sticky storage-corruption flag
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         err_echo_parity <= 1'b0;
      end else begin
         err_echo_parity <= par_err_s ? 1'b1 : (err_clear ? 1'b0 : err_echo_parity);
      end
   end
`endif

endmodule

// File: tb/tb_sifive_insight_tl_echo_tracker.sv
// Self-checking bench for sifive_insight_tl_echo_tracker: directed scenarios plus a randomized run
// against a behavioural table model.
module tb_sifive_insight_tl_echo_tracker;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       a_valid, a_ready, d_valid, d_ready, err_clear;
   logic [3:0] a_source, d_source;
   logic [7:0] a_echo;
   logic [2:0] d_opcode, d_size;
   logic [7:0] d_echo;
   logic       d_echo_valid, idle, err_dup_source, err_orphan_d;
   logic [4:0] outstanding;
`ifdef SIFIVE_INSIGHT_ECHO_PARITY_EN
   logic       err_echo_parity;
`endif

   int checks = 0;
   int passed = 0;

   // behavioural model state
   bit         m_valid [16];
   logic [7:0] m_echo  [16];
   bit         m_burst;
   int         m_beat, m_beats, m_src;
   bit         m_dup, m_orph;

   always #5 clock = ~clock;

   sifive_insight_tl_echo_tracker dut (
      .clock(clock), .reset_n(reset_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_source(a_source), .a_echo(a_echo),
      .d_valid(d_valid), .d_ready(d_ready), .d_source(d_source), .d_opcode(d_opcode), .d_size(d_size),
      .d_echo(d_echo), .d_echo_valid(d_echo_valid), .outstanding(outstanding), .idle(idle),
      .err_clear(err_clear),
`ifdef SIFIVE_INSIGHT_ECHO_PARITY_EN
      .err_echo_parity(err_echo_parity),
`endif
      .err_dup_source(err_dup_source), .err_orphan_d(err_orphan_d)
   );

   function automatic int m_count();
      int n = 0;
      for (int i = 0; i < 16; i++) n += int'(m_valid[i]);
      return n;
   endfunction

   function automatic int beats_of(input logic [2:0] op, input logic [2:0] sz);
      if ((op == 3'd1 || op == 3'd5) && sz > 3'd3) return 1 << (int'(sz) - 3);
      return 1;
   endfunction

   // Applies one clock edge of TileLink semantics to the model using the inputs in force at the edge
   task automatic model_step();
      bit af, df, hit, last, free, dup_set, orph_set;
      int src;
      if (!reset_n) begin
         for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
         m_burst = 0; m_beat = 0; m_beats = 1; m_dup = 0; m_orph = 0;
         return;
      end
      af = a_valid && a_ready;
      df = d_valid && d_ready;
      if (df && !m_burst) begin
         m_src = int'(d_source); m_beats = beats_of(d_opcode, d_size); m_beat = 0;
      end
      src      = m_burst ? m_src : int'(d_source);
      hit      = m_valid[src];
      last     = df && (m_beat == m_beats - 1);
      free     = last && hit;
      dup_set  = af && m_valid[a_source] && !(free && src == int'(a_source));
      orph_set = df && !hit;
      if (free) m_valid[src] = 1'b0;
      if (af) begin m_valid[a_source] = 1'b1; m_echo[a_source] = a_echo; end
      if (df) begin
         if (last) begin m_burst = 0; m_beat = 0; end
         else begin m_burst = 1; m_beat++; end
      end
      m_dup  = dup_set  ? 1'b1 : (err_clear ? 1'b0 : m_dup);
      m_orph = orph_set ? 1'b1 : (err_clear ? 1'b0 : m_orph);
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      #1;
   endtask

   task automatic quiet_inputs();
      a_valid = 1'b0; a_ready = 1'b1; d_valid = 1'b0; d_ready = 1'b1; err_clear = 1'b0;
      a_source = 4'd0; a_echo = 8'd0; d_source = 4'd0; d_opcode = 3'd0; d_size = 3'd3;
   endtask

   task automatic do_reset();
      reset_n = 1'b0; tick(); reset_n = 1'b1;
   endtask

   task automatic test_reset();
      quiet_inputs();
      reset_n = 1'b0; tick(); tick(); reset_n = 1'b1;
      checks++; if (outstanding !== 5'd0) $display("FAIL reset_outstanding got %0d want 0", outstanding); else passed++;
      checks++; if (idle !== 1'b1) $display("FAIL reset_idle got %b want 1", idle); else passed++;
      checks++; if (err_dup_source !== 1'b0 || err_orphan_d !== 1'b0)
         $display("FAIL reset_errs got dup=%b orph=%b want 0 0", err_dup_source, err_orphan_d); else passed++;
      d_valid = 1'b1; d_source = 4'd3; #1;
      checks++; if (d_echo_valid !== 1'b0 || d_echo !== 8'h00)
         $display("FAIL reset_echo got v=%b e=%h want 0 00", d_echo_valid, d_echo); else passed++;
      d_valid = 1'b0;
   endtask

   task automatic test_basic();
      a_valid = 1'b1; a_source = 4'd3; a_echo = 8'hA5; tick(); a_valid = 1'b0;
      checks++; if (outstanding !== 5'd1 || idle !== 1'b0)
         $display("FAIL basic_alloc got out=%0d idle=%b want 1 0", outstanding, idle); else passed++;
      d_valid = 1'b1; d_source = 4'd3; d_opcode = 3'd0; d_size = 3'd3; #1;
      checks++; if (d_echo !== 8'hA5 || d_echo_valid !== 1'b1)
         $display("FAIL basic_echo got e=%h v=%b want a5 1", d_echo, d_echo_valid); else passed++;
      tick(); d_valid = 1'b0;
      checks++; if (outstanding !== 5'd0 || idle !== 1'b1 || err_orphan_d !== 1'b0)
         $display("FAIL basic_free got out=%0d idle=%b orph=%b want 0 1 0", outstanding, idle, err_orphan_d); else passed++;
   endtask

   task automatic test_burst();
      a_valid = 1'b1; a_source = 4'd2; a_echo = 8'h11; tick(); a_valid = 1'b0;
      d_valid = 1'b1; d_source = 4'd2; d_opcode = 3'd1; d_size = 3'd5;
      for (int b = 0; b < 4; b++) begin
         #1;
         checks++; if (d_echo !== 8'h11 || d_echo_valid !== 1'b1)
            $display("FAIL burst_echo beat %0d got e=%h v=%b want 11 1", b, d_echo, d_echo_valid); else passed++;
         tick();
         checks++; if (outstanding !== ((b < 3) ? 5'd1 : 5'd0) || idle !== (b == 3))
            $display("FAIL burst_state beat %0d got out=%0d idle=%b", b, outstanding, idle); else passed++;
         if (b == 1) begin
            d_ready = 1'b0; tick(); d_ready = 1'b1;
            checks++; if (outstanding !== 5'd1 || idle !== 1'b0)
               $display("FAIL burst_stall got out=%0d idle=%b want 1 0", outstanding, idle); else passed++;
         end
      end
      d_valid = 1'b0;
      checks++; if (err_orphan_d !== 1'b0) $display("FAIL burst_orphan got %b want 0", err_orphan_d); else passed++;
   endtask

   task automatic test_dup();
      a_valid = 1'b1; a_source = 4'd1; a_echo = 8'h22; tick();
      a_echo = 8'h33; tick(); a_valid = 1'b0;
      checks++; if (err_dup_source !== 1'b1 || outstanding !== 5'd1)
         $display("FAIL dup_flag got dup=%b out=%0d want 1 1", err_dup_source, outstanding); else passed++;
      d_valid = 1'b1; d_source = 4'd1; d_opcode = 3'd0; #1;
      checks++; if (d_echo !== 8'h33) $display("FAIL dup_echo got %h want 33", d_echo); else passed++;
      tick(); d_valid = 1'b0;
      err_clear = 1'b1; tick(); err_clear = 1'b0;
      checks++; if (err_dup_source !== 1'b0 || outstanding !== 5'd0)
         $display("FAIL dup_clear got dup=%b out=%0d want 0 0", err_dup_source, outstanding); else passed++;
   endtask

   task automatic test_orphan();
      d_valid = 1'b1; d_source = 4'd7; d_opcode = 3'd0; tick(); d_valid = 1'b0;
      checks++; if (err_orphan_d !== 1'b1 || outstanding !== 5'd0)
         $display("FAIL orphan_set got orph=%b out=%0d want 1 0", err_orphan_d, outstanding); else passed++;
      err_clear = 1'b1; tick(); err_clear = 1'b0;
      checks++; if (err_orphan_d !== 1'b0) $display("FAIL orphan_clear got %b want 0", err_orphan_d); else passed++;
      d_valid = 1'b1; err_clear = 1'b1; tick(); d_valid = 1'b0; err_clear = 1'b0;
      checks++; if (err_orphan_d !== 1'b1) $display("FAIL orphan_set_over_clear got %b want 1", err_orphan_d); else passed++;
      err_clear = 1'b1; tick(); err_clear = 1'b0;
   endtask

   task automatic test_same_cycle();
      a_valid = 1'b1; a_source = 4'd4; a_echo = 8'h77; tick(); a_valid = 1'b0;
      d_valid = 1'b1; d_source = 4'd4; d_opcode = 3'd1; d_size = 3'd4; tick();
      a_valid = 1'b1; a_echo = 8'h3C; #1;
      checks++; if (d_echo !== 8'h77) $display("FAIL same_old_echo got %h want 77", d_echo); else passed++;
      tick(); a_valid = 1'b0; d_valid = 1'b0;
      checks++; if (err_dup_source !== 1'b0 || outstanding !== 5'd1 || err_orphan_d !== 1'b0)
         $display("FAIL same_src got dup=%b out=%0d orph=%b want 0 1 0", err_dup_source, outstanding, err_orphan_d); else passed++;
      d_valid = 1'b1; d_opcode = 3'd0; d_size = 3'd0; #1;
      checks++; if (d_echo !== 8'h3C || d_echo_valid !== 1'b1)
         $display("FAIL same_new_echo got e=%h v=%b want 3c 1", d_echo, d_echo_valid); else passed++;
      tick(); d_valid = 1'b0;
      a_valid = 1'b1; a_source = 4'd5; a_echo = 8'h55; tick();
      a_source = 4'd6; a_echo = 8'h66; d_valid = 1'b1; d_source = 4'd5; tick();
      a_valid = 1'b0; d_valid = 1'b0;
      checks++; if (outstanding !== 5'd1 || err_dup_source !== 1'b0)
         $display("FAIL diff_src got out=%0d dup=%b want 1 0", outstanding, err_dup_source); else passed++;
      d_valid = 1'b1; d_source = 4'd6; #1;
      checks++; if (d_echo !== 8'h66) $display("FAIL diff_echo got %h want 66", d_echo); else passed++;
      tick(); d_valid = 1'b0;
   endtask

   task automatic test_fill_reset();
      for (int i = 0; i < 16; i++) begin
         a_valid = 1'b1; a_source = 4'(i); a_echo = 8'(i * 3 + 1); tick();
      end
      a_valid = 1'b0;
      checks++; if (outstanding !== 5'd16 || idle !== 1'b0)
         $display("FAIL fill got out=%0d idle=%b want 16 0", outstanding, idle); else passed++;
      d_valid = 1'b1; d_source = 4'd0; d_opcode = 3'd5; d_size = 3'd6; tick(); tick();
      checks++; if (outstanding !== 5'd16 || idle !== 1'b0)
         $display("FAIL midburst got out=%0d idle=%b want 16 0", outstanding, idle); else passed++;
      reset_n = 1'b0; tick(); reset_n = 1'b1;
      checks++; if (outstanding !== 5'd0 || idle !== 1'b1)
         $display("FAIL burst_reset got out=%0d idle=%b want 0 1", outstanding, idle); else passed++;
      tick(); d_valid = 1'b0;
      checks++; if (err_orphan_d !== 1'b1 || idle !== 1'b0)
         $display("FAIL post_reset_orphan got orph=%b idle=%b want 1 0", err_orphan_d, idle); else passed++;
      do_reset();
   endtask

   task automatic test_random();
      logic [2:0] ops [4];
      int pick;
      ops[0] = 3'd0; ops[1] = 3'd1; ops[2] = 3'd4; ops[3] = 3'd5;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         a_valid   = 1'($urandom_range(0, 1));
         a_ready   = ($urandom_range(0, 3) != 0);
         a_source  = 4'($urandom_range(0, 15));
         a_echo    = 8'($urandom_range(0, 255));
         d_valid   = ($urandom_range(0, 2) != 0);
         d_ready   = ($urandom_range(0, 3) != 0);
         err_clear = ($urandom_range(0, 7) == 0);
         if (!m_burst) begin
            pick = $urandom_range(0, 15);
            if ($urandom_range(0, 3) != 0) begin
               for (int k = 0; k < 16; k++) begin
                  if (m_valid[(pick + k) % 16]) begin pick = (pick + k) % 16; break; end
               end
            end
            d_source = 4'(pick);
            d_opcode = ops[$urandom_range(0, 3)];
            d_size   = 3'($urandom_range(0, 6));
         end
         #1;
         checks++; if (d_echo_valid !== (d_valid && m_valid[d_source]))
            $display("FAIL rnd_echo_valid cyc %0d got %b want %b", n, d_echo_valid, d_valid && m_valid[d_source]); else passed++;
         checks++; if (d_echo !== (m_valid[d_source] ? m_echo[d_source] : 8'h00))
            $display("FAIL rnd_echo cyc %0d got %h want %h", n, d_echo, m_valid[d_source] ? m_echo[d_source] : 8'h00); else passed++;
         tick();
         checks++; if (outstanding !== 5'(m_count()))
            $display("FAIL rnd_outstanding cyc %0d got %0d want %0d", n, outstanding, m_count()); else passed++;
         checks++; if (idle !== (m_count() == 0 && !m_burst))
            $display("FAIL rnd_idle cyc %0d got %b want %b", n, idle, (m_count() == 0 && !m_burst)); else passed++;
         checks++; if (err_dup_source !== m_dup || err_orphan_d !== m_orph)
            $display("FAIL rnd_errs cyc %0d got dup=%b orph=%b want %b %b", n, err_dup_source, err_orphan_d, m_dup, m_orph); else passed++;
`ifdef SIFIVE_INSIGHT_ECHO_PARITY_EN
         checks++; if (err_echo_parity !== 1'b0)
            $display("FAIL rnd_parity cyc %0d got %b want 0", n, err_echo_parity); else passed++;
`endif
      end
      quiet_inputs();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_burst();
      test_dup();
      test_orphan();
      test_same_cycle();
      test_fill_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
